dog_img: RTL and testbench

DOG_IMG -- requirements
Module: dog_img

---
 rtl/dog_img.sv | 87 ++++++++
 tb/tb_dog_img.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/dog_img.sv
// Difference-of-Gaussians stage: streams two source images out of BRAM and writes the
// signed per-pixel difference (sharper - fuzzier) to a destination address stream.
module dog_img #(
  parameter int BIT_DEPTH = 8,
  parameter int WIDTH     = 64,
  parameter int HEIGHT    = 64,
  localparam int N        = WIDTH * HEIGHT,
  localparam int AW       = $clog2(N)
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 start_in,
  output logic [AW-1:0]        read_addr,
  output logic                 read_addr_valid,
  input  logic [BIT_DEPTH-1:0] sharper_pixel_in,
  input  logic [BIT_DEPTH-1:0] fuzzier_pixel_in,
  output logic [AW-1:0]        write_addr,
  output logic                 write_valid,
  output logic [BIT_DEPTH:0]   pixel_out,
  output logic                 dog_done
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRead  = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  localparam logic [AW-1:0] LastAddr = AW'(N - 1);

  logic [1:0]           state_q, state_d;
  logic                 valid1_q, valid2_q;
  logic [AW-1:0]        addr1_q, addr2_q;
  logic [BIT_DEPTH:0]   diff;

  // Zero-extend both operands so the result spans the full signed range without wrapping.
  assign diff = {1'b0, sharper_pixel_in} - {1'b0, fuzzier_pixel_in};

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start_in) state_d = StRead;
      StRead:  if (read_addr == LastAddr) state_d = StDrain;
      StDrain: if (write_valid && write_addr == LastAddr) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q         <= StIdle;
      read_addr       <= '0;
      read_addr_valid <= 1'b0;
      valid1_q        <= 1'b0;
      valid2_q        <= 1'b0;
      addr1_q         <= '0;
      addr2_q         <= '0;
      write_valid     <= 1'b0;
      write_addr      <= '0;
      pixel_out       <= '0;
      dog_done        <= 1'b0;
    end else begin
      state_q  <= state_d;
      dog_done <= (state_d == StDone);

      if (state_q == StIdle && start_in) begin
        read_addr       <= '0;
        read_addr_valid <= 1'b1;
      end else if (state_q == StRead) begin
        if (read_addr == LastAddr) read_addr_valid <= 1'b0;
        else read_addr <= read_addr + 1'b1;
      end

      // Two stages cover the BRAM latency; the output register is the third.
      valid1_q    <= read_addr_valid;
      addr1_q     <= read_addr;
      valid2_q    <= valid1_q;
      addr2_q     <= addr1_q;
      write_valid <= valid2_q;
      if (valid2_q) begin
        write_addr <= addr2_q;
        pixel_out  <= diff;
      end
    end
  end

endmodule

// File: tb/tb_dog_img.sv
// Randomized self-checking bench for dog_img: BRAM model with 2-cycle read latency and a
// per-pass reference of expected write timing, addresses and signed differences.
module tb_dog_img;

  localparam int BD = 8;
  localparam int W  = 64;
  localparam int H  = 64;
  localparam int N  = W * H;
  localparam int AW = $clog2(N);

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic          start_in = 1'b0;
  logic [AW-1:0] read_addr;
  logic          read_addr_valid;
  logic [BD-1:0] sharper_pixel_in;
  logic [BD-1:0] fuzzier_pixel_in;
  logic [AW-1:0] write_addr;
  logic          write_valid;
  logic [BD:0]   pixel_out;
  logic          dog_done;

  int checks = 0;
  int failures = 0;

  logic [BD-1:0] sh_mem [N];
  logic [BD-1:0] fz_mem [N];
  int            exp_pix [N];
  logic [BD-1:0] sh_d1 = '0, fz_d1 = '0;

  dog_img #(.BIT_DEPTH(BD), .WIDTH(W), .HEIGHT(H)) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .start_in         (start_in),
    .read_addr        (read_addr),
    .read_addr_valid  (read_addr_valid),
    .sharper_pixel_in (sharper_pixel_in),
    .fuzzier_pixel_in (fuzzier_pixel_in),
    .write_addr       (write_addr),
    .write_valid      (write_valid),
    .pixel_out        (pixel_out),
    .dog_done         (dog_done)
  );

  always #5 clk_in = ~clk_in;

  // Source BRAMs: registered read plus output register gives data two cycles after address.
  initial begin
    sharper_pixel_in = '0;
    fuzzier_pixel_in = '0;
  end
  always @(posedge clk_in) begin
    if (read_addr_valid) begin
      sh_d1 <= sh_mem[read_addr];
      fz_d1 <= fz_mem[read_addr];
    end
    sharper_pixel_in <= sh_d1;
    fuzzier_pixel_in <= fz_d1;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic load(input int pat);
    for (int a = 0; a < N; a++) begin
      case (pat)
        0: begin sh_mem[a] = 8'd100; fz_mem[a] = 8'd40; end
        1: begin sh_mem[a] = 8'd0;   fz_mem[a] = 8'd255; end
        2: begin sh_mem[a] = 8'd255; fz_mem[a] = 8'd0; end
        3: begin sh_mem[a] = BD'(a % 256); fz_mem[a] = BD'((a * 3) % 256); end
        default: begin sh_mem[a] = BD'($urandom); fz_mem[a] = BD'($urandom); end
      endcase
      exp_pix[a] = int'(sh_mem[a]) - int'(fz_mem[a]);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".read_addr"}, int'(read_addr), 0);
    check({tag, ".read_addr_valid"}, int'(read_addr_valid), 0);
    check({tag, ".write_addr"}, int'(write_addr), 0);
    check({tag, ".write_valid"}, int'(write_valid), 0);
    check({tag, ".pixel_out"}, int'(pixel_out), 0);
    check({tag, ".dog_done"}, int'(dog_done), 0);
  endtask

  // Pass starts at edge T; cycle c is the cycle T+c. Extra starts x0/x1, reset at rst_at (0=none).
  task automatic run_pass(input string name, input int pat, input int x0, input int x1,
                          input int rst_at, input bit b2b);
    int last;
    int writes;
    int dones;
    bit aborted;
    load(pat);
    last = b2b ? N + 4 : N + 6;
    writes = 0;
    dones = 0;
    start_in = 1'b1;
    @(posedge clk_in); #1;
    start_in = 1'b0;
    for (int c = 1; c <= last; c++) begin
      start_in = (c == x0 || c == x1);
      rst_in = (rst_at != 0 && c == rst_at);
      aborted = (rst_at != 0 && c > rst_at);
      @(negedge clk_in);
      if (aborted) begin
        if (c == rst_at + 1) check_idle_outputs({name, ".post_rst"});
        if (write_valid) check($sformatf("%s.stray_write c=%0d", name, c), 1, 0);
        if (dog_done) check($sformatf("%s.stray_done c=%0d", name, c), 1, 0);
      end else begin
        if (c <= N) begin
          if (!read_addr_valid || int'(read_addr) != c - 1)
            check($sformatf("%s.read c=%0d", name, c), int'(read_addr), c - 1);
        end else if (c == N + 1) begin
          check({name, ".drain_valid"}, int'(read_addr_valid), 0);
          check({name, ".drain_addr"}, int'(read_addr), N - 1);
        end
        if (c >= 4 && c <= N + 3) begin
          if (!write_valid) check($sformatf("%s.write_valid c=%0d", name, c), 0, 1);
          else begin
            writes++;
            if (int'(write_addr) != c - 4)
              check($sformatf("%s.write_addr c=%0d", name, c), int'(write_addr), c - 4);
            if (int'($signed(pixel_out)) != exp_pix[c - 4])
              check($sformatf("%s.pixel a=%0d", name, c - 4), int'($signed(pixel_out)),
                    exp_pix[c - 4]);
          end
        end else if (write_valid) check($sformatf("%s.extra_write c=%0d", name, c), 1, 0);
        if (dog_done) begin
          dones++;
          check($sformatf("%s.done_cycle", name), c, N + 4);
        end
      end
      @(posedge clk_in); #1;
    end
    start_in = 1'b0;
    rst_in = 1'b0;
    check({name, ".writes"}, writes, rst_at != 0 ? rst_at - 3 : N);
    check({name, ".dones"}, dones, rst_at != 0 ? 0 : 1);
  endtask

  initial begin
    rst_in = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    @(negedge clk_in);
    check_idle_outputs("reset");

    // Reset wins over a simultaneous start.
    start_in = 1'b1;
    @(posedge clk_in); #1;
    start_in = 1'b0;
    rst_in = 1'b0;
    @(negedge clk_in);
    check("rst_prio.valid", int'(read_addr_valid), 0);
    @(posedge clk_in); #1;
    @(negedge clk_in);
    check("rst_prio.valid2", int'(read_addr_valid), 0);
    @(posedge clk_in); #1;

    run_pass("const", 0, 0, 0, 0, 1'b0);
    run_pass("neg", 1, 0, 0, 0, 1'b0);
    run_pass("pos", 2, 0, 0, 0, 1'b0);
    run_pass("ramp", 3, 100, N + 3, 0, 1'b0);
    run_pass("abort", 4, 0, 0, 2000, 1'b0);
    run_pass("rand", 4, 0, 0, 0, 1'b1);
    run_pass("b2b", 3, 0, 0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=1 exp=0");
    $fatal(1, "timeout");
  end

endmodule
